// File: rtl/alu_unit_pkg.sv
// alu_unit_pkg: opcode encodings, flag bit positions and the flags layout
// shared by the ALU datapath and its register/bus plumbing.
package alu_unit_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_ADC = 3'd1,
        OP_SUB = 3'd2,
        OP_SBC = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_SHR = 3'd7
    } alu_op_e;

    localparam int F_C = 0;
    localparam int F_Z = 1;
    localparam int F_V = 2;
    localparam int F_N = 3;

    localparam int DATA_W = 8;
    localparam int FLAG_W = 4;

    // Flags as held in the register: {N,V,Z,C}, carry in bit 0.
    typedef struct packed {
        logic n;
        logic v;
        logic z;
        logic c;
    } flags_t;

endpackage

// File: rtl/alu_unit_core.sv
// alu_core: purely combinational 8-bit operation and next-flags generator.
// Also holds the two board-level primitives the ALU stage is assembled from:
// dff_173 (clocked register with active-low load) and buffer_245 (tri-state
// bus driver with active-low output enable).
module alu_core
    import alu_unit_pkg::*;
(
    input  logic [DATA_W-1:0] l,
    input  logic [DATA_W-1:0] r,
    input  logic [2:0]        op,
    input  logic              cin,
    output logic [DATA_W-1:0] res,
    output logic [FLAG_W-1:0] nf
);
    logic [DATA_W-1:0] rr;
    logic [DATA_W:0]   sum;
    logic              ci;
    logic              arith;
    logic              c;
    logic              v;
    flags_t            f;

    // Arithmetic ops share one 9-bit adder; subtraction feeds ~R with carry-in.
    always_comb begin
        rr    = r;
        ci    = 1'b0;
        arith = 1'b0;
        c     = cin;
        v     = 1'b0;
        res   = '0;
        case (op)
            OP_ADD: begin rr = r;  ci = 1'b0; arith = 1'b1; end
            OP_ADC: begin rr = r;  ci = cin;  arith = 1'b1; end
            OP_SUB: begin rr = ~r; ci = 1'b1; arith = 1'b1; end
            OP_SBC: begin rr = ~r; ci = cin;  arith = 1'b1; end
            OP_AND: res = l & r;
            OP_OR:  res = l | r;
            OP_XOR: res = l ^ r;
            OP_SHR: begin res = {1'b0, l[DATA_W-1:1]}; c = l[0]; end
            default: res = '0;
        endcase
        sum = {1'b0, l} + {1'b0, rr} + {{DATA_W{1'b0}}, ci};
        if (arith) begin
            res = sum[DATA_W-1:0];
            c   = sum[DATA_W];
            // Overflow: operands agree in sign but the result does not.
            v   = (l[DATA_W-1] == rr[DATA_W-1]) && (sum[DATA_W-1] != l[DATA_W-1]);
        end
        f.n = res[DATA_W-1];
        f.v = v;
        f.z = (res == '0);
        f.c = c;
        nf  = f;
    end

endmodule

module dff_173 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    // Capture d when load_n is low; reset clears asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (!load_n)
            q <= d;
    end

endmodule

module buffer_245 #(
    parameter int W = 8
) (
    input  logic         oe_n,
    input  logic [W-1:0] a,
    output wire  [W-1:0] y
);
    assign y = oe_n ? {W{1'bz}} : a;

endmodule

// File: rtl/alu_unit.sv
// alu_unit: ALU stage. Computes from the operand buses, holds result and
// flags in registers, and drives either onto the shared data bus. The flags
// register can also be loaded from the bus to save/restore status.
module alu_unit
    import alu_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] alu_l,
    input  logic [DATA_W-1:0] alu_r,
    input  logic [2:0]        op,
    input  logic              calcn,
    input  logic              fcalcn,
    input  logic              floadn,
    input  logic              outn,
    input  logic              foutn,
    inout  wire  [DATA_W-1:0] bus,
    output logic [FLAG_W-1:0] flags
);
    logic [DATA_W-1:0] res_next;
    logic [FLAG_W-1:0] flags_next;
    logic [FLAG_W-1:0] flags_d;
    logic [DATA_W-1:0] result;
    logic              flags_ld_n;
    logic              res_oe_n;
    logic              flg_oe_n;

    alu_core u_core (
        .l   (alu_l),
        .r   (alu_r),
        .op  (op),
        .cin (flags[F_C]),
        .res (res_next),
        .nf  (flags_next)
    );

    dff_173 #(.W(DATA_W)) u_res_reg (
        .clk    (clk),
        .reset  (reset),
        .load_n (calcn),
        .d      (res_next),
        .q      (result)
    );

    // A bus load beats a flag calculation in the same cycle.
    assign flags_d    = !floadn ? bus[FLAG_W-1:0] : flags_next;
    assign flags_ld_n = floadn & fcalcn;

    dff_173 #(.W(FLAG_W)) u_flag_reg (
        .clk    (clk),
        .reset  (reset),
        .load_n (flags_ld_n),
        .d      (flags_d),
        .q      (flags)
    );

    // Result wins the bus if both drives are requested; both float in reset.
    assign res_oe_n = outn | reset;
    assign flg_oe_n = foutn | ~outn | reset;

    buffer_245 #(.W(DATA_W)) u_res_buf (
        .oe_n (res_oe_n),
        .a    (result),
        .y    (bus)
    );

    buffer_245 #(.W(DATA_W)) u_flg_buf (
        .oe_n (flg_oe_n),
        .a    ({{(DATA_W-FLAG_W){1'b0}}, flags}),
        .y    (bus)
    );

endmodule
